fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the word-addressed MIPS pipeline. Owns the PC register.
//  Presents pc to the next-PC selector and loads the selector's next-PC result (npc).
//  Fetches from instruction memory over a req/ack handshake and fills the IF/ID
//  pipeline register. Honours hazard-unit stalls and ID-stage redirects
//  (taken branch, j, jal, jr).
// PARAMETERS
//  RESET_PC   32'h0000_0000  word address loaded into pc on reset
//  NOP_INSTR  32'h0000_0000  encoding driven on ifid_instr for bubbles/reset
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   reset, asynchronous, active-high
//  npc         in   32  next PC (word address) from next-PC selector; sampled per rules below
//  redirect    in   1   ID resolved taken branch/jump; npc carries target
//  stall       in   1   hazard unit: hold IF/ID contents
//  imem_req    out  1   fetch request
//  imem_addr   out  32  fetch word address (= pc)
//  imem_ack    in   1   one-cycle pulse; imem_rdata valid; may coincide with req cycle
//  imem_rdata  in   32  fetched instruction
//  pc          out  32  current fetch PC (to next-PC selector in_pc)
//  ifid_valid  out  1   IF/ID holds a real instruction
//  ifid_pc     out  32  PC of instruction in IF/ID
//  ifid_instr  out  32  instruction in IF/ID (NOP_INSTR when !ifid_valid)
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=FETCH, ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR, hold buffer empty.
//   Memory is reset by the same rst; no ack from a pre-reset request reaches this block.
//  imem_req = (state==FETCH); imem_addr = pc. req/addr stable until ack. Max one outstanding.
//  States:
//   FETCH: ack & !redirect & !stall -> IF/ID <= {1,pc,rdata}; pc<=npc; stay FETCH (1 instr/cycle when ack same cycle).
//          ack & !redirect & stall  -> hold buf <= {pc,rdata}; pc<=npc; go HOLD.
//          !ack & !stall & !redirect -> ifid_valid<=0 (bubble), instr<=NOP_INSTR.
//          !ack & stall -> IF/ID unchanged.
//   HOLD:  req=0. !stall & !redirect -> IF/ID <= hold buf; go FETCH. stall -> remain.
//   DRAIN: req=0; stale request outstanding. ack -> data dropped, go FETCH. No IF/ID load.
//  redirect (any state, priority over stall): pc<=npc; ifid_valid<=0, instr<=NOP_INSTR; hold buf cleared.
//   FETCH & !ack -> DRAIN; FETCH & ack -> data dropped, stay FETCH; HOLD -> FETCH; DRAIN -> stay DRAIN.
//  redirect & stall same cycle: redirect wins, IF/ID flushed.
//  pc loads only from npc or RESET_PC; no internal +1 (sequential increment is in selector, wraps mod 2^32).
//  Outputs registered except imem_req/imem_addr/pc (decoded from state/pc regs).
// STRUCTURE
//  cpu_pkg: typedef enum logic[1:0] {FETCH,HOLD,DRAIN} fetch_state_t; NOP_INSTR constant.
//  Sub-module ifid_reg: IF/ID register with load/hold/flush, reused by later stage regs.
//  fetch_stage: FSM, pc reg, one-entry hold buffer, ifid_reg instance.
// TESTING
//  1 Zero-wait mem (ack=req), npc=pc+1, no stall -> ifid_pc 0,1,2,3 in consecutive cycles, valid=1.
//  2 Ack latency 3 cycles -> 2 bubble cycles (ifid_valid=0, NOP) between instructions; addr stable during wait.
//  3 stall=1 when ack for pc=5 arrives -> HOLD, req=0, IF/ID keeps pc=4; stall drop -> ifid_pc=5 next cycle.
//  4 redirect with npc=0x40 while request for pc=7 outstanding -> DRAIN; late ack dropped; next req addr=0x40.
//  5 redirect+stall same cycle in HOLD -> ifid_valid=0, hold buf cleared, next req addr=npc.
//  6 rst asserted mid-FETCH (async, off-edge) -> outputs reset immediately; pc=RESET_PC, req=1 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the word-addressed MIPS pipeline.
//   fetch_state_t : fetch-stage FSM encoding
//   NOP_INSTR     : encoding used for pipeline bubbles and reset contents
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding (imem_req high)
        HOLD  = 2'd1,   // fetched word parked while ID is stalled
        DRAIN = 2'd2    // waiting out a request made stale by a redirect
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline stage register: {valid, pc, instr}.
//   clk, rst        : clock, asynchronous active-high reset
//   load            : capture in_pc/in_instr, mark valid
//   flush           : clear valid and force FLUSH_INSTR (wins over load); pc kept
//   in_pc, in_instr : incoming payload
//   out_valid, out_pc, out_instr : registered contents
// With neither load nor flush the contents are held.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] FLUSH_INSTR = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = FLUSH_INSTR;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            instr_d = in_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            instr_q <= FLUSH_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// fills the IF/ID register. Honours stalls and ID-stage redirects.
//   clk, rst      : clock, asynchronous active-high reset
//   npc           : next PC from the next-PC selector (target when redirect)
//   redirect      : ID resolved a taken branch/jump; flushes IF/ID
//   stall         : hazard unit holds IF/ID
//   imem_req/addr : fetch request and word address (= pc)
//   imem_ack/rdata: one-cycle response pulse and instruction word
//   pc            : current fetch PC
//   ifid_*        : IF/ID register contents
//   dbg_state     : FSM state, for observation only
// Handshake: imem_req is high exactly in FETCH and imem_addr equals pc; neither
// changes until the cycle imem_ack is seen (which may be the request cycle).
// At most one request is outstanding; a request abandoned by a redirect is
// retired in DRAIN, where its data is discarded.
module fetch_stage
    import cpu_pkg::fetch_state_t, cpu_pkg::FETCH, cpu_pkg::HOLD, cpu_pkg::DRAIN;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  npc,
    input  logic         redirect,
    input  logic         stall,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  pc,
    output logic         ifid_valid,
    output logic [31:0]  ifid_pc,
    output logic [31:0]  ifid_instr,
    output fetch_state_t dbg_state
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         hold_valid_q, hold_valid_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic [31:0]  hold_instr_q, hold_instr_d;

    logic         ifid_load, ifid_flush;
    logic [31:0]  ifid_in_pc, ifid_in_instr;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_valid_d  = hold_valid_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_in_pc    = pc_q;
        ifid_in_instr = imem_rdata;

        if (redirect) begin
            // Redirect beats stall: the wrong-path fetch and anything parked
            // in the hold buffer are both discarded.
            pc_d         = npc;
            ifid_flush   = 1'b1;
            hold_valid_d = 1'b0;
            unique case (state_q)
                FETCH:   state_d = imem_ack ? FETCH : DRAIN;
                HOLD:    state_d = FETCH;
                // An ack landing now retires the stale request.
                DRAIN:   state_d = imem_ack ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        pc_d = npc;
                        if (stall) begin
                            hold_valid_d = 1'b1;
                            hold_pc_d    = pc_q;
                            hold_instr_d = imem_rdata;
                            state_d      = HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_flush = 1'b1;  // bubble while waiting on memory
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_load     = 1'b1;
                        ifid_in_pc    = hold_pc_q;
                        ifid_in_instr = hold_instr_q;
                        hold_valid_d  = 1'b0;
                        state_d       = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            hold_valid_q <= 1'b0;
            hold_pc_q    <= 32'd0;
            hold_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_valid_q <= hold_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    ifid_reg #(.FLUSH_INSTR(NOP_INSTR)) u_ifid (
        .clk       (clk),
        .rst       (rst),
        .load      (ifid_load),
        .flush     (ifid_flush),
        .in_pc     (ifid_in_pc),
        .in_instr  (ifid_in_instr),
        .out_valid (ifid_valid),
        .out_pc    (ifid_pc),
        .out_instr (ifid_instr)
    );

    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import cpu_pkg::*;

    logic         clk;
    logic         rst;
    logic [31:0]  npc;
    logic         redirect;
    logic         stall;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;
    logic [31:0]  pc;
    logic         ifid_valid;
    logic [31:0]  ifid_pc;
    logic [31:0]  ifid_instr;
    fetch_state_t dbg_state;

    // Environment models: next-PC selector and instruction memory.
    logic         zero_wait;   // ack mirrors req in the same cycle
    logic         ack_drv;
    logic         use_target;
    logic [31:0]  target;

    int cmp_count  = 0;
    int fail_count = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h8C00_0000 | (a & 32'h00FF_FFFF);
    endfunction

    assign npc        = use_target ? target : pc + 32'd1;
    assign imem_ack   = zero_wait ? imem_req : ack_drv;
    assign imem_rdata = instr_of(imem_addr);

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .npc        (npc),
        .redirect   (redirect),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .ifid_valid (ifid_valid),
        .ifid_pc    (ifid_pc),
        .ifid_instr (ifid_instr),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; zero_wait = 1'b1; ack_drv = 1'b0;
        use_target = 1'b0; target = 32'd0; redirect = 1'b0; stall = 1'b0;
        #2;
        cmp_count++; if (ifid_valid !== 1'b0) begin fail_count++; $display("FAIL rst_valid: got %b want 0", ifid_valid); end
        cmp_count++; if (ifid_instr !== 32'd0) begin fail_count++; $display("FAIL rst_instr: got %h want 00000000", ifid_instr); end
        cmp_count++; if (pc !== 32'd0) begin fail_count++; $display("FAIL rst_pc: got %h want 00000000", pc); end
        tick(); tick();
        rst = 1'b0;
        cmp_count++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin fail_count++; $display("FAIL rst_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 4; i++) begin
            tick();
            cmp_count++;
            if (ifid_valid !== 1'b1 || ifid_pc !== i || ifid_instr !== instr_of(i)) begin
                fail_count++;
                $display("FAIL zw_%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", i, ifid_valid, ifid_pc, ifid_instr, i, instr_of(i));
            end
        end
        cmp_count++; if (pc !== 32'd4) begin fail_count++; $display("FAIL zw_pc: got %h want 00000004", pc); end
    endtask

    task automatic test_latency();
        zero_wait = 1'b0; ack_drv = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            cmp_count++;
            if (ifid_valid !== 1'b0 || ifid_instr !== 32'd0 || imem_req !== 1'b1 || imem_addr !== 32'd4) begin
                fail_count++;
                $display("FAIL lat_bubble_%0d: got v=%b instr=%h req=%b addr=%h want v=0 instr=0 req=1 addr=4", i, ifid_valid, ifid_instr, imem_req, imem_addr);
            end
        end
        ack_drv = 1'b1;
        tick();
        cmp_count++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'd4 || ifid_instr !== instr_of(32'd4) || pc !== 32'd5) begin
            fail_count++;
            $display("FAIL lat_arrive: got v=%b ifid_pc=%h instr=%h pc=%h want v=1 ifid_pc=4 pc=5", ifid_valid, ifid_pc, ifid_instr, pc);
        end
    endtask

    task automatic test_stall_hold();
        ack_drv = 1'b1; stall = 1'b1;
        tick();
        cmp_count++;
        if (dbg_state !== HOLD || imem_req !== 1'b0 || ifid_pc !== 32'd4 || ifid_valid !== 1'b1) begin
            fail_count++;
            $display("FAIL stall_enter: got st=%0d req=%b ifid_pc=%h v=%b want st=HOLD req=0 ifid_pc=4 v=1", dbg_state, imem_req, ifid_pc, ifid_valid);
        end
        ack_drv = 1'b0;
        tick();
        cmp_count++;
        if (dbg_state !== HOLD || ifid_pc !== 32'd4 || ifid_valid !== 1'b1) begin
            fail_count++;
            $display("FAIL stall_keep: got st=%0d ifid_pc=%h v=%b want HOLD 4 1", dbg_state, ifid_pc, ifid_valid);
        end
        stall = 1'b0;
        tick();
        cmp_count++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'd5 || ifid_instr !== instr_of(32'd5)) begin
            fail_count++;
            $display("FAIL stall_release: got v=%b pc=%h instr=%h want v=1 pc=5 instr=%h", ifid_valid, ifid_pc, ifid_instr, instr_of(32'd5));
        end
        cmp_count++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd6) begin
            fail_count++;
            $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=6", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_drain();
        ack_drv = 1'b1;
        tick();             // pc=6 fetched, pc=7 now outstanding
        ack_drv = 1'b0; redirect = 1'b1; use_target = 1'b1; target = 32'h40;
        tick();
        redirect = 1'b0; use_target = 1'b0;
        cmp_count++;
        if (dbg_state !== DRAIN || imem_req !== 1'b0 || ifid_valid !== 1'b0 || pc !== 32'h40) begin
            fail_count++;
            $display("FAIL drain_enter: got st=%0d req=%b v=%b pc=%h want DRAIN 0 0 40", dbg_state, imem_req, ifid_valid, pc);
        end
        ack_drv = 1'b1;     // late ack for pc=7
        tick();
        cmp_count++;
        if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            fail_count++;
            $display("FAIL drain_drop: got v=%b req=%b addr=%h want v=0 req=1 addr=40", ifid_valid, imem_req, imem_addr);
        end
        tick();
        cmp_count++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h40 || ifid_instr !== instr_of(32'h40)) begin
            fail_count++;
            $display("FAIL drain_target: got v=%b pc=%h instr=%h want v=1 pc=40", ifid_valid, ifid_pc, ifid_instr);
        end
    endtask

    task automatic test_redirect_stall_hold();
        ack_drv = 1'b1; stall = 1'b1;
        tick();             // pc=0x41 parked in hold buffer
        cmp_count++; if (dbg_state !== HOLD) begin fail_count++; $display("FAIL rs_hold: got st=%0d want HOLD", dbg_state); end
        ack_drv = 1'b0; redirect = 1'b1; use_target = 1'b1; target = 32'h80;
        tick();
        redirect = 1'b0; use_target = 1'b0;
        cmp_count++;
        if (ifid_valid !== 1'b0 || ifid_instr !== 32'd0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            fail_count++;
            $display("FAIL rs_flush: got v=%b instr=%h req=%b addr=%h want v=0 instr=0 req=1 addr=80", ifid_valid, ifid_instr, imem_req, imem_addr);
        end
        stall = 1'b0; ack_drv = 1'b1;
        tick();
        cmp_count++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h80 || ifid_instr !== instr_of(32'h80)) begin
            fail_count++;
            $display("FAIL rs_holdclr: got v=%b pc=%h instr=%h want v=1 pc=80", ifid_valid, ifid_pc, ifid_instr);
        end
    endtask

    task automatic test_async_reset();
        zero_wait = 1'b1;
        tick();
        #3;
        rst = 1'b1;
        #1;
        cmp_count++;
        if (ifid_valid !== 1'b0 || ifid_pc !== 32'd0 || ifid_instr !== 32'd0 || pc !== 32'd0) begin
            fail_count++;
            $display("FAIL arst_now: got v=%b ifid_pc=%h instr=%h pc=%h want all 0", ifid_valid, ifid_pc, ifid_instr, pc);
        end
        tick();
        #2;
        rst = 1'b0;
        cmp_count++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || dbg_state !== FETCH) begin
            fail_count++;
            $display("FAIL arst_release: got req=%b addr=%h st=%0d want req=1 addr=0 FETCH", imem_req, imem_addr, dbg_state);
        end
        tick();
        cmp_count++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'd0 || pc !== 32'd1) begin
            fail_count++;
            $display("FAIL arst_refetch: got v=%b ifid_pc=%h pc=%h want v=1 ifid_pc=0 pc=1", ifid_valid, ifid_pc, pc);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_hold();
        test_redirect_drain();
        test_redirect_stall_hold();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
